// File: rtl/jk_cmd_sequencer.sv
// Command sequencer that queues {op,len} commands and drives a downstream JK flip-flop,
// applying each op for len+1 cycles while tracking the predicted flip-flop output.
module jk_cmd_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [3:0] cmd_len,
    output logic       j,
    output logic       k,
    output logic       busy,
    output logic       done,
    output logic       q_model,
    output logic [2:0] fifo_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [2:0] DEPTH_C = 3'(DEPTH);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_APPLY = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [5:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [2:0]       count_q, count_d;
    logic [3:0]       remain_q, remain_d;
    logic             j_q, j_d;
    logic             k_q, k_d;
    logic             q_q, q_d;
    logic             push_s;
    logic             pop_s;
    logic             busy_s;
    logic             done_s;
    logic [5:0]       head_s;

    // Readiness uses only the registered count, so a same-cycle pop never admits a push into a full queue
    assign cmd_ready  = (count_q < DEPTH_C);
    assign push_s     = cmd_valid && cmd_ready;
    assign head_s     = mem_q[rd_ptr_q];

    assign j          = j_q;
    assign k          = k_q;
    assign q_model    = q_q;
    assign fifo_count = count_q;
    assign busy       = busy_s;
    assign done       = done_s;

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= 3'd0;
            remain_q <= 4'd0;
            j_q      <= 1'b0;
            k_q      <= 1'b0;
            q_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            remain_q <= remain_d;
            j_q      <= j_d;
            k_q      <= k_d;
            q_q      <= q_d;
        end
    end

    // Command storage written at the tail on every accepted push
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= {cmd_op, cmd_len};
        end
    end

    // Next-state logic: a finishing command hands over to the next one without a gap
    always_comb begin
        state_d = state_q;
        pop_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (count_q != 3'd0) begin
                    pop_s   = 1'b1;
                    state_d = ST_APPLY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_APPLY: begin
                if (remain_q != 4'd0) begin
                    state_d = ST_APPLY;
                end else if (count_q != 3'd0) begin
                    pop_s   = 1'b1;
                    state_d = ST_APPLY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Status outputs decoded from the current state
    always_comb begin
        busy_s = 1'b0;
        done_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy_s = 1'b0;
                done_s = 1'b0;
            end
            ST_APPLY: begin
                busy_s = 1'b1;
                done_s = (remain_q == 4'd0);
            end
            default: begin
                busy_s = 1'b0;
                done_s = 1'b0;
            end
        endcase
    end

    // Datapath next values: drive loading, apply countdown, queue bookkeeping and JK prediction
    always_comb begin
        j_d      = 1'b0;
        k_d      = 1'b0;
        remain_d = 4'd0;
        q_d      = q_q;
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;

        if (pop_s) begin
            j_d      = head_s[5];
            k_d      = head_s[4];
            remain_d = head_s[3:0];
        end else if ((state_q == ST_APPLY) && (remain_q != 4'd0)) begin
            j_d      = j_q;
            k_d      = k_q;
            remain_d = remain_q - 4'd1;
        end else begin
            j_d      = 1'b0;
            k_d      = 1'b0;
            remain_d = 4'd0;
        end

        if (state_q == ST_APPLY) begin
            case ({j_q, k_q})
                2'b00:   q_d = q_q;
                2'b01:   q_d = 1'b0;
                2'b10:   q_d = 1'b1;
                2'b11:   q_d = ~q_q;
                default: q_d = q_q;
            endcase
        end else begin
            q_d = q_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Self-checking bench for jk_cmd_sequencer: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_jk_cmd_sequencer;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_len;
    logic       j;
    logic       k;
    logic       busy;
    logic       done;
    logic       q_model;
    logic [2:0] fifo_count;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [1:0] op;
        logic [3:0] len;
    } cmd_t;

    // Reference model: pending queue, the command being applied and cycles it has left
    cmd_t       mq[$];
    bit         m_active;
    logic [1:0] m_op;
    int         m_left;
    logic       m_q;

    jk_cmd_sequencer #(.DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_len    (cmd_len),
        .j          (j),
        .k          (k),
        .busy       (busy),
        .done       (done),
        .q_model    (q_model),
        .fifo_count (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_step(input logic v, input logic [1:0] op, input logic [3:0] len, input logic r);
        bit   acc;
        cmd_t c;
        if (r) begin
            mq.delete();
            m_active = 1'b0;
            m_op     = 2'b00;
            m_left   = 0;
            m_q      = 1'b0;
            return;
        end
        acc = v && (mq.size() < 4);
        if (m_active) begin
            case (m_op)
                2'b01:   m_q = 1'b0;
                2'b10:   m_q = 1'b1;
                2'b11:   m_q = ~m_q;
                default: m_q = m_q;
            endcase
            m_left = m_left - 1;
            if (m_left == 0) m_active = 1'b0;
        end
        if (!m_active && mq.size() > 0) begin
            c        = mq.pop_front();
            m_active = 1'b1;
            m_op     = c.op;
            m_left   = int'(c.len) + 1;
        end
        if (acc) begin
            c.op  = op;
            c.len = len;
            mq.push_back(c);
        end
    endfunction

    // {ready, j, k, busy, done, q, count}
    function automatic logic [8:0] model_outs();
        logic       rdy;
        logic       dn;
        logic [2:0] cnt;
        rdy = (mq.size() < 4) ? 1'b1 : 1'b0;
        dn  = (m_active && m_left == 1) ? 1'b1 : 1'b0;
        cnt = 3'(mq.size());
        return {rdy, m_active & m_op[1], m_active & m_op[0], m_active, dn, m_q, cnt};
    endfunction

    function automatic logic [8:0] dut_outs();
        return {cmd_ready, j, k, busy, done, q_model, fifo_count};
    endfunction

    task automatic tick(input logic v, input logic [1:0] op, input logic [3:0] len, input logic r);
        cmd_valid = v;
        cmd_op    = op;
        cmd_len   = len;
        rst       = r;
        @(posedge clk);
        model_step(v, op, len, r);
        #1;
    endtask

    task automatic test_reset();
        tick(1'b1, 2'b10, 4'd3, 1'b1);
        tick(1'b1, 2'b11, 4'd1, 1'b1);
        checks++;
        if (dut_outs() !== 9'b1_0000_0000) begin
            errors++;
            $display("FAIL reset_state: got %b want %b", dut_outs(), 9'b1_0000_0000);
        end
        tick(1'b0, 2'b00, 4'd0, 1'b0);
        checks++;
        if (dut_outs() !== model_outs()) begin
            errors++;
            $display("FAIL reset_idle: got %b want %b", dut_outs(), model_outs());
        end
    endtask

    task automatic test_set_single();
        tick(1'b0, 2'b00, 4'd0, 1'b1);
        tick(1'b1, 2'b10, 4'd0, 1'b0);
        checks++;
        if (fifo_count !== 3'd1 || j !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL set_accept: got cnt=%0d j=%b busy=%b want cnt=1 j=0 busy=0", fifo_count, j, busy);
        end
        tick(1'b0, 2'b00, 4'd0, 1'b0);
        checks++;
        if ({j, k, busy, done, fifo_count} !== 7'b1011_000) begin
            errors++;
            $display("FAIL set_apply: got %b want %b", {j, k, busy, done, fifo_count}, 7'b1011_000);
        end
        tick(1'b0, 2'b00, 4'd0, 1'b0);
        checks++;
        if ({j, k, busy, done, q_model} !== 5'b00001) begin
            errors++;
            $display("FAIL set_after: got %b want %b", {j, k, busy, done, q_model}, 5'b00001);
        end
    endtask

    task automatic test_toggle();
        tick(1'b0, 2'b00, 4'd0, 1'b1);
        tick(1'b1, 2'b11, 4'd2, 1'b0);
        for (int c = 0; c < 3; c++) begin
            tick(1'b0, 2'b00, 4'd0, 1'b0);
            checks++;
            if (j !== 1'b1 || k !== 1'b1 || done !== (c == 2) || q_model !== logic'(c % 2)) begin
                errors++;
                $display("FAIL toggle_c%0d: got j=%b k=%b done=%b q=%b want j=1 k=1 done=%b q=%0d",
                         c, j, k, done, q_model, (c == 2), c % 2);
            end
        end
        tick(1'b0, 2'b00, 4'd0, 1'b0);
        checks++;
        if (q_model !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL toggle_end: got q=%b busy=%b want q=1 busy=0", q_model, busy);
        end
    endtask

    task automatic test_fill();
        logic [1:0] ops[6];
        logic [1:0] got[$];
        int         idx;
        bit         started;
        bit         will_acc;
        int         guard;
        for (int i = 0; i < 6; i++) ops[i] = 2'(i % 4);
        tick(1'b0, 2'b00, 4'd0, 1'b1);
        idx     = 0;
        started = 1'b0;
        guard   = 0;
        while (!(idx == 6 && !m_active && mq.size() == 0) && guard < 100) begin
            will_acc = (idx < 6) && (mq.size() < 4);
            tick(idx < 6, (idx < 6) ? ops[idx] : 2'b00, 4'd3, 1'b0);
            if (will_acc) idx++;
            guard++;
            checks++;
            if (dut_outs() !== model_outs()) begin
                errors++;
                $display("FAIL fill_cycle%0d: got %b want %b", guard, dut_outs(), model_outs());
            end
            if (fifo_count == 3'd4) begin
                checks++;
                if (cmd_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL fill_ready_full: got %b want 0", cmd_ready);
                end
            end
            if (busy === 1'b1) started = 1'b1;
            if (started && got.size() < 6) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL fill_gap: got busy=%b want 1 at cycle %0d", busy, guard);
                end
            end
            if (done === 1'b1) got.push_back({j, k});
        end
        checks++;
        if (guard >= 100) begin
            errors++;
            $display("FAIL fill_timeout: got %0d cycles want under 100", guard);
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (i >= got.size() || got[i] !== ops[i]) begin
                errors++;
                $display("FAIL fill_order%0d: got %b want %b", i, (i < got.size()) ? got[i] : 2'bxx, ops[i]);
            end
        end
    endtask

    task automatic test_full_pop();
        int guard;
        int n_done;
        tick(1'b0, 2'b00, 4'd0, 1'b1);
        tick(1'b1, 2'b01, 4'd15, 1'b0);
        for (int i = 0; i < 4; i++) tick(1'b1, 2'b10, 4'd0, 1'b0);
        checks++;
        if (fifo_count !== 3'd4 || cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_state: got cnt=%0d rdy=%b want cnt=4 rdy=0", fifo_count, cmd_ready);
        end
        guard = 0;
        while (done !== 1'b1 && guard < 40) begin
            tick(1'b1, 2'b11, 4'd0, 1'b0);
            guard++;
        end
        checks++;
        if (guard >= 40 || fifo_count !== 3'd4 || cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_done_cycle: got guard=%0d cnt=%0d rdy=%b want cnt=4 rdy=0", guard, fifo_count, cmd_ready);
        end
        tick(1'b1, 2'b11, 4'd0, 1'b0);
        checks++;
        if (fifo_count !== 3'd3 || cmd_ready !== 1'b1 || dut_outs() !== model_outs()) begin
            errors++;
            $display("FAIL full_pop: got %b want %b", dut_outs(), model_outs());
        end
        n_done = 0;
        guard  = 0;
        while ((busy === 1'b1 || fifo_count != 3'd0) && guard < 40) begin
            if (done === 1'b1) n_done++;
            tick(1'b0, 2'b00, 4'd0, 1'b0);
            guard++;
        end
        checks++;
        if (n_done != 4 || guard >= 40) begin
            errors++;
            $display("FAIL full_rejected: got %0d done pulses want 4", n_done);
        end
    endtask

    task automatic test_reset_mid();
        tick(1'b0, 2'b00, 4'd0, 1'b1);
        tick(1'b1, 2'b01, 4'd5, 1'b0);
        tick(1'b1, 2'b10, 4'd1, 1'b0);
        tick(1'b1, 2'b11, 4'd1, 1'b0);
        checks++;
        if (busy !== 1'b1 || fifo_count !== 3'd2 || {j, k} !== 2'b01) begin
            errors++;
            $display("FAIL rstmid_pre: got busy=%b cnt=%0d jk=%b want 1 2 01", busy, fifo_count, {j, k});
        end
        tick(1'b1, 2'b10, 4'd0, 1'b1);
        checks++;
        if ({j, k, busy, done, q_model, fifo_count} !== 8'b0) begin
            errors++;
            $display("FAIL rstmid_post: got %b want 0", {j, k, busy, done, q_model, fifo_count});
        end
        for (int c = 0; c < 20; c++) begin
            tick(1'b0, 2'b00, 4'd0, 1'b0);
            checks++;
            if (busy !== 1'b0 || done !== 1'b0 || fifo_count !== 3'd0 || {j, k} !== 2'b00) begin
                errors++;
                $display("FAIL rstmid_quiet%0d: got busy=%b done=%b cnt=%0d jk=%b want 0", c, busy, done, fifo_count, {j, k});
            end
        end
    endtask

    task automatic test_sequence();
        logic [1:0] seq[6];
        logic       qexp[6];
        logic       qprev;
        seq[0] = 2'b00; seq[1] = 2'b01; seq[2] = 2'b10; seq[3] = 2'b11; seq[4] = 2'b11; seq[5] = 2'b00;
        qexp[0] = 1'b0; qexp[1] = 1'b0; qexp[2] = 1'b1; qexp[3] = 1'b0; qexp[4] = 1'b1; qexp[5] = 1'b1;
        tick(1'b0, 2'b00, 4'd0, 1'b1);
        tick(1'b1, seq[0], 4'd0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick(i < 4, seq[i + 1], 4'd0, 1'b0);
            qprev = (i == 0) ? 1'b0 : qexp[i - 1];
            checks++;
            if ({j, k} !== seq[i] || done !== 1'b1 || q_model !== qprev) begin
                errors++;
                $display("FAIL seq_step%0d: got jk=%b done=%b q=%b want jk=%b done=1 q=%b",
                         i, {j, k}, done, q_model, seq[i], qprev);
            end
        end
        tick(1'b0, 2'b00, 4'd0, 1'b0);
        checks++;
        if (q_model !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL seq_end: got q=%b busy=%b want q=1 busy=0", q_model, busy);
        end
    endtask

    task automatic test_random();
        logic       v;
        logic       r;
        logic [1:0] op;
        logic [3:0] len;
        tick(1'b0, 2'b00, 4'd0, 1'b1);
        for (int c = 0; c < 400; c++) begin
            v   = logic'($urandom_range(0, 1));
            op  = 2'($urandom_range(0, 3));
            len = 4'($urandom_range(0, 3));
            r   = ($urandom_range(0, 63) == 0) ? 1'b1 : 1'b0;
            tick(v, op, len, r);
            checks++;
            if (dut_outs() !== model_outs()) begin
                errors++;
                $display("FAIL random_cycle%0d: got %b want %b", c, dut_outs(), model_outs());
            end
        end
        tick(1'b1, 2'b10, 4'd2, 1'b1);
        checks++;
        if (dut_outs() !== 9'b1_0000_0000) begin
            errors++;
            $display("FAIL random_final_reset: got %b want %b", dut_outs(), 9'b1_0000_0000);
        end
    endtask

    initial begin
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_len   = 4'd0;
        rst       = 1'b1;
        m_active  = 1'b0;
        m_op      = 2'b00;
        m_left    = 0;
        m_q       = 1'b0;
        test_reset();
        test_set_single();
        test_toggle();
        test_fill();
        test_full_pop();
        test_reset_mid();
        test_sequence();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/jk_cmd_sequencer.md
JK_CMD_SEQUENCER -- requirements
Module: jk_cmd_sequencer

Interface
REQ-001 Parameter DEPTH, default 4, is the command FIFO depth in entries; only DEPTH=4 is required.
REQ-002 clk  input  1  single clock; all state changes on posedge clk.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-004 cmd_valid  input  1  command offered this cycle.
REQ-005 cmd_ready  output  1  FIFO can accept a command this cycle.
REQ-006 cmd_op  input  2  requested {j,k}: 00 hold, 01 reset, 10 set, 11 toggle.
REQ-007 cmd_len  input  4  apply cycles minus one; the op is applied for cmd_len+1 cycles (1..16).
REQ-008 j  output  1  registered J drive to the downstream JK flip-flop.
REQ-009 k  output  1  registered K drive to the downstream JK flip-flop.
REQ-010 busy  output  1  high while in APPLY.
REQ-011 done  output  1  one-cycle pulse on the final apply cycle of each command.
REQ-012 q_model  output  1  predicted downstream q, updated as a JK flip-flop clocked by clk.
REQ-013 fifo_count  output  3  number of queued commands (0..4), excluding the one being applied.

Function
REQ-014 A command SHALL be accepted at a posedge where cmd_valid && cmd_ready; the accepted {cmd_op, cmd_len} SHALL be written to the FIFO tail.
REQ-015 cmd_ready SHALL equal (fifo_count < DEPTH), using the registered count. A pop in the same cycle SHALL NOT make a full FIFO accept.
REQ-016 The FSM SHALL have two states: IDLE and APPLY.
REQ-017 IDLE, fifo_count>0: at the next posedge, pop the head, load j,k=op and remain=len, and go to APPLY.
REQ-018 IDLE, fifo_count==0: j=0, k=0 and busy=0 SHALL hold.
REQ-019 APPLY, remain>0: at each posedge, decrement remain and hold j,k.
REQ-020 APPLY, remain==0: done=1 SHALL assert combinationally in that cycle; at the next posedge, pop the next entry back-to-back with no gap cycle if fifo_count>0, else go to IDLE with j=k=0.
REQ-021 When a push and a pop occur at the same posedge, fifo_count SHALL be unchanged and both operations SHALL take effect.
REQ-022 Latency: a command accepted at posedge N into an empty FIFO while IDLE SHALL drive j,k after posedge N+1.
REQ-023 FIFO read and write pointers SHALL be 2 bits and wrap from 3 to 0; commands SHALL leave strictly in arrival order.
REQ-024 q_model SHALL update at every posedge while in APPLY using the current j,k: 00 hold, 01 to 0, 10 to 1, 11 invert. It SHALL hold while in IDLE.
REQ-025 cmd_op=00 SHALL still occupy cmd_len+1 APPLY cycles and pulse done.

Reset
REQ-026 While rst=1 at a posedge, the block SHALL go to IDLE and clear j, k, busy, done, q_model, fifo_count, the pointers and remain to 0.
REQ-027 Reset mid-APPLY or with a non-empty FIFO SHALL discard all pending commands, with no done pulse.
REQ-028 cmd_valid during reset SHALL be ignored; cmd_ready SHALL read 1 in the first cycle after reset deasserts.

Verification
REQ-029 Reset, then push op=10 len=0: j=1,k=0 for exactly 1 cycle with done=1, q_model=1 afterwards, then j=k=0 and busy=0.
REQ-030 Push op=11 len=2 from q_model=0: j=k=1 for 3 cycles, q_model toggles 0 to 1 to 0 to 1, done only on the third cycle.
REQ-031 Push 5 commands on consecutive cycles while IDLE: first 4 accepted, cmd_ready=0 when fifo_count=4, 5th accepted only after the first pop; all 5 applied in order with no idle gaps.
REQ-032 Push while full with a simultaneous pop: push rejected, fifo_count goes 4 to 3, cmd_ready=1 the next cycle.
REQ-033 Assert rst during the 2nd cycle of op=01 len=5 with 2 queued: after reset, j=k=0, fifo_count=0, q_model=0, no done pulse, no further activity.
REQ-034 Sequence 00, 01, 10, 11, 11 each with len=0: j/k follow the sequence on successive cycles, and q_model ends at 1 (0, 0, 1, 0, 1).
